// File: rtl/jt900h_fetch_pkg.sv
// Shared types and constants for the jt900h instruction prefetch queue.
//   fetch_state_t  : bus read state machine encoding
//   OP_BYTES       : number of bytes presented to the control unit on op
//   next_word_addr : byte address of the first byte of the following bus word
package jt900h_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  localparam int OP_BYTES = 4;

  // Step to the next 16-bit word boundary; wraps modulo 2^24.
  function automatic logic [23:0] next_word_addr(input logic [23:0] addr);
    return {addr[23:1] + 23'd1, 1'b0};
  endfunction

endpackage

// File: rtl/jt900h_fetch_if.sv
// Signal bundle between the prefetch queue, the CPU control unit and the
// program bus.
//   master : the fetch unit (drives op/op_ok/pc and the bus request)
//   slave  : its environment (control unit + program bus)
// Control unit: cen, fetched[1:0], jmp, jmp_addr[23:0] -> op[31:0], op_ok, pc[23:0]
// Program bus : bus_din[15:0], bus_ok, bus_busy -> bus_addr[22:0], bus_rd
interface jt900h_fetch_if;

  logic        cen;
  logic [1:0]  fetched;
  logic        jmp;
  logic [23:0] jmp_addr;
  logic [31:0] op;
  logic        op_ok;
  logic [23:0] pc;
  logic [22:0] bus_addr;
  logic        bus_rd;
  logic [15:0] bus_din;
  logic        bus_ok;
  logic        bus_busy;

  modport master (
    input  cen, fetched, jmp, jmp_addr, bus_din, bus_ok, bus_busy,
    output op, op_ok, pc, bus_addr, bus_rd
  );

  modport slave (
    output cen, fetched, jmp, jmp_addr, bus_din, bus_ok, bus_busy,
    input  op, op_ok, pc, bus_addr, bus_rd
  );

endinterface

// File: rtl/jt900h_fetch_bytefifo.sv
// QDEPTH-byte circular store for the prefetch queue.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : empty the queue (wins over push/pop)
//   push_n    : bytes written this cycle (0-2), push_data[7:0] goes first
//   pop_n     : bytes released this cycle (0-3), caller never pops past count
//   peek      : next OP_BYTES bytes from the head, byte 0 in [7:0]
//   count     : valid bytes held (0..QDEPTH)
module jt900h_fetch_bytefifo
  import jt900h_fetch_pkg::*;
#(
  parameter int QDEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [1:0]                push_n,
  input  logic [15:0]               push_data,
  input  logic [1:0]                pop_n,
  output logic [8*OP_BYTES-1:0]     peek,
  output logic [$clog2(QDEPTH):0]   count
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [QDEPTH];
  logic [7:0]    mem_d [QDEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state of storage and pointers; pointers wrap naturally (power-of-two depth).
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_n != 2'd0) begin
        mem_d[wr_ptr_q] = push_data[7:0];
      end else begin
        mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      end
      if (push_n == 2'd2) begin
        mem_d[wr_ptr_q + AW'(2'd1)] = push_data[15:8];
      end else begin
        mem_d[wr_ptr_q + AW'(2'd1)] = mem_q[wr_ptr_q + AW'(2'd1)];
      end
      wr_ptr_d = wr_ptr_q + AW'(push_n);
      rd_ptr_d = rd_ptr_q + AW'(pop_n);
      count_d  = count_q + CW'(push_n) - CW'(pop_n);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= 8'd0;
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head window: byte k of the peek is the k-th oldest queued byte.
  always_comb begin
    peek = {(8*OP_BYTES){1'b0}};
    for (int k = 0; k < OP_BYTES; k++) begin
      peek[8*k +: 8] = mem_q[rd_ptr_q + AW'(k)];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/jt900h_fetch.sv
// Instruction prefetch queue for the jt900h CPU.
// Reads 16-bit program words into a byte queue and shows the next four bytes
// on op. The control unit reports consumed bytes on fetched, which advances pc.
// A jump flushes the queue and restarts fetching from jmp_addr.
//   clk, rst : clock, asynchronous active-high reset
//   io       : jt900h_fetch_if master (control unit + program bus signals)
// Parameters: QDEPTH queue bytes (power of two, >=6), PC_RST reset pc.
module jt900h_fetch
  import jt900h_fetch_pkg::*;
#(
  parameter int          QDEPTH = 8,
  parameter logic [23:0] PC_RST = 24'd0
) (
  input  logic           clk,
  input  logic           rst,
  jt900h_fetch_if.master io
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [23:0]   pc_q, pc_d;
  logic [23:0]   faddr_q, faddr_d;     // next byte address to request
  logic          bus_rd_q, bus_rd_d;
  logic [22:0]   bus_addr_q, bus_addr_d;

  logic          flush_s;
  logic [1:0]    push_n_s;
  logic [15:0]   push_data_s;
  logic [1:0]    pop_n_s;
  logic [31:0]   peek_s;
  logic [CW-1:0] count_s;
  logic          op_ok_s;
  logic          free_ok_s;

  jt900h_fetch_bytefifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_s),
    .push_n    (push_n_s),
    .push_data (push_data_s),
    .pop_n     (pop_n_s),
    .peek      (peek_s),
    .count     (count_s)
  );

  assign op_ok_s   = (count_s >= CW'(OP_BYTES));
  // Room for a full word is reserved when a read starts, so bytes consumed
  // in the same cycle are deliberately not credited here.
  assign free_ok_s = ((CW'(QDEPTH) - count_s) >= CW'(2'd2));

  // Consume, bus FSM next state and jump handling.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    faddr_d     = faddr_q;
    bus_rd_d    = bus_rd_q;
    bus_addr_d  = bus_addr_q;
    flush_s     = 1'b0;
    push_n_s    = 2'd0;
    push_data_s = io.bus_din;
    pop_n_s     = 2'd0;
    if (io.cen) begin
      // fetched only counts while op is valid; a jump overrides it
      if (op_ok_s && !io.jmp) begin
        pop_n_s = io.fetched;
        pc_d    = pc_q + 24'(io.fetched);
      end else begin
        pop_n_s = 2'd0;
      end

      case (state_q)
        ST_IDLE: begin
          if (!io.jmp && !io.bus_busy && free_ok_s) begin
            state_d    = ST_READ;
            bus_rd_d   = 1'b1;
            bus_addr_d = faddr_q[23:1];
          end else begin
            state_d    = ST_IDLE;
          end
        end
        ST_READ: begin
          if (io.bus_ok) begin
            state_d  = ST_IDLE;
            bus_rd_d = 1'b0;
            if (!io.jmp) begin
              faddr_d = next_word_addr(faddr_q);
              // odd start address: only the high byte belongs to the stream
              if (faddr_q[0]) begin
                push_n_s    = 2'd1;
                push_data_s = {8'h00, io.bus_din[15:8]};
              end else begin
                push_n_s    = 2'd2;
                push_data_s = io.bus_din;
              end
            end else begin
              push_n_s = 2'd0;
            end
          end else if (io.jmp) begin
            // request must still complete on the bus; its data is stale
            state_d = ST_DISCARD;
          end else begin
            state_d = ST_READ;
          end
        end
        ST_DISCARD: begin
          if (io.bus_ok) begin
            state_d  = ST_IDLE;
            bus_rd_d = 1'b0;
          end else begin
            state_d  = ST_DISCARD;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          bus_rd_d = 1'b0;
        end
      endcase

      if (io.jmp) begin
        pc_d    = io.jmp_addr;
        faddr_d = io.jmp_addr;
        flush_s = 1'b1;
      end else begin
        flush_s = 1'b0;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Control and bus request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= PC_RST;
      faddr_q    <= PC_RST;
      bus_rd_q   <= 1'b0;
      bus_addr_q <= PC_RST[23:1];
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      faddr_q    <= faddr_d;
      bus_rd_q   <= bus_rd_d;
      bus_addr_q <= bus_addr_d;
    end
  end

  // op is forced to zero while fewer than four bytes are queued.
  assign io.op       = op_ok_s ? peek_s : 32'd0;
  assign io.op_ok    = op_ok_s;
  assign io.pc       = pc_q;
  assign io.bus_rd   = bus_rd_q;
  assign io.bus_addr = bus_addr_q;

endmodule
